// File: rtl/stochastic_frame_controller_if.sv
// Handshake and datapath bundle between the frame controller, the LFSR, the ReSC core and the result consumer.
interface stochastic_frame_controller_if #(
   parameter int WIDTH = 10
) ();
   logic             start;
   logic [WIDTH-1:0] x_value;
   logic [WIDTH-1:0] lfsr_data;
   logic             lfsr_restart;
   logic             lfsr_enable;
   logic             x_bit;
   logic             z_bit;
   logic             busy;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH:0]   z_count;

   modport master (
      input  start, x_value, lfsr_data, z_bit, result_ready,
      output lfsr_restart, lfsr_enable, x_bit, busy, result_valid, z_count
   );

   modport slave (
      output start, x_value, lfsr_data, z_bit, result_ready,
      input  lfsr_restart, lfsr_enable, x_bit, busy, result_valid, z_count
   );
endinterface

// File: rtl/stochastic_frame_controller.sv
// Runs the LFSR for one full period, emits x_bit = (lfsr_data < x_reg) and counts z_bit ones;
// result appears 2^WIDTH+2 cycles after start and is held under result_valid until result_ready.
module stochastic_frame_controller #(
   parameter int WIDTH = 10
) (
   input  logic clk,
   input  logic reset,
   stochastic_frame_controller_if.master bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] cycle_cnt;
   logic [WIDTH:0]   ones_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         x_reg     <= '0;
         cycle_cnt <= '0;
         ones_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  x_reg     <= bus.x_value;
                  cycle_cnt <= '0;
                  ones_cnt  <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: state <= RUN;
            RUN: begin
               cycle_cnt <= cycle_cnt + 1'b1;
               if (bus.z_bit) begin
                  ones_cnt <= ones_cnt + 1'b1;
               end
               // Wrap of the cycle counter marks the last word of the LFSR period.
               if (cycle_cnt == '1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.lfsr_restart = (state == LOAD);
   assign bus.lfsr_enable  = (state == RUN);
   assign bus.busy         = (state == LOAD) || (state == RUN);
   assign bus.result_valid = (state == DONE);
   assign bus.z_count      = ones_cnt;
   // Only combinational output: the core needs the bit in the same cycle as lfsr_data.
   assign bus.x_bit        = (state == RUN) && (bus.lfsr_data < x_reg);
endmodule

// File: tb/tb_stochastic_frame_controller.sv
// Directed bench: drives a 10-bit added-zero LFSR model and checks counts, latency and handshake.
module tb_stochastic_frame_controller;
   logic clk;
   logic reset;
   int   zmode;   // 0: loopback z=x, 1: z tied high, 2: z tied low
   int   checks;
   int   errors;

   stochastic_frame_controller_if #(.WIDTH(10)) bus ();

   stochastic_frame_controller #(.WIDTH(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // x^10 + x^7 + 1 with the all-zero state spliced in: period 1024, seed 10'h001.
   logic [9:0] lfsr;
   always @(posedge clk) begin
      if (bus.lfsr_restart) begin
         lfsr <= 10'h001;
      end else if (bus.lfsr_enable) begin
         lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6] ^ (lfsr[8:0] == 9'd0)};
      end
   end
   assign bus.lfsr_data = lfsr;
   assign bus.z_bit = (zmode == 0) ? bus.x_bit : (zmode == 1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [9:0] x, input bit disturb,
                            output logic [10:0] cnt, output int lat,
                            output int n_rst, output int rst_lat, output int n_en);
      bit done;
      done = 1'b0;
      n_rst = 0; n_en = 0; rst_lat = -1; lat = 0; cnt = '0;
      @(negedge clk);
      bus.x_value = x;
      bus.start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!done && lat < 1200) begin
         if (bus.lfsr_restart) begin
            n_rst++;
            rst_lat = lat;
         end
         if (bus.lfsr_enable) n_en++;
         if (bus.result_valid) begin
            done = 1'b1;
            cnt  = bus.z_count;
         end else begin
            if (disturb && lat == 100) begin
               bus.start   = 1'b1;
               bus.x_value = ~x;
            end
            if (disturb && lat == 101) bus.start = 1'b0;
            @(negedge clk);
            lat++;
         end
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL frame_timeout: got no result_valid, expected one by cycle 1026");
      end
   endtask

   typedef struct {
      logic [9:0]  x;
      int          zm;
      logic [10:0] exp;
      bit          disturb;
   } vec_t;

   vec_t vecs[7];

   task automatic check_frame(input string tag, input logic [10:0] exp,
                              input logic [10:0] cnt, input int lat,
                              input int n_rst, input int rst_lat, input int n_en);
      check({tag, "_z_count"}, 32'(cnt), 32'(exp));
      check({tag, "_latency"}, 32'(lat), 32'd1026);
      check({tag, "_restart_count"}, 32'(n_rst), 32'd1);
      check({tag, "_restart_cycle"}, 32'(rst_lat), 32'd1);
      check({tag, "_enable_cycles"}, 32'(n_en), 32'd1024);
      check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [10:0] cnt;
      int lat, n_rst, rst_lat, n_en;
      checks = 0;
      errors = 0;
      zmode  = 0;
      lfsr   = 10'h001;
      vecs[0] = '{x: 10'd0,    zm: 0, exp: 11'd0,    disturb: 1'b0};
      vecs[1] = '{x: 10'd512,  zm: 0, exp: 11'd512,  disturb: 1'b0};
      vecs[2] = '{x: 10'd1023, zm: 0, exp: 11'd1023, disturb: 1'b0};
      vecs[3] = '{x: 10'd5,    zm: 1, exp: 11'd1024, disturb: 1'b0};
      vecs[4] = '{x: 10'd700,  zm: 2, exp: 11'd0,    disturb: 1'b0};
      vecs[5] = '{x: 10'd1,    zm: 0, exp: 11'd1,    disturb: 1'b0};
      vecs[6] = '{x: 10'd300,  zm: 0, exp: 11'd300,  disturb: 1'b1};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.x_value = '0;
      bus.result_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_z_count", 32'(bus.z_count), 32'd0);
      check("rst_result_valid", 32'(bus.result_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_lfsr_restart", 32'(bus.lfsr_restart), 32'd0);
      check("rst_lfsr_enable", 32'(bus.lfsr_enable), 32'd0);
      check("rst_x_bit", 32'(bus.x_bit), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         zmode = vecs[i].zm;
         run_frame(vecs[i].x, vecs[i].disturb, cnt, lat, n_rst, rst_lat, n_en);
         check_frame($sformatf("vec%0d", i), vecs[i].exp, cnt, lat, n_rst, rst_lat, n_en);
         if (i == 1) begin
            for (int c = 0; c < 50; c++) begin
               @(negedge clk);
               check("hold_valid", 32'(bus.result_valid), 32'd1);
               check("hold_z_count", 32'(bus.z_count), 32'(vecs[i].exp));
            end
         end
         bus.result_ready = 1'b1;
         @(negedge clk);
         bus.result_ready = 1'b0;
         check("post_hs_valid", 32'(bus.result_valid), 32'd0);
         check("post_hs_busy", 32'(bus.busy), 32'd0);
         check("post_hs_z_count", 32'(bus.z_count), 32'(vecs[i].exp));
         @(negedge clk);
         check("idle_no_restart", 32'(bus.lfsr_restart), 32'd0);
      end

      // Reset in the middle of RUN, then a clean frame.
      zmode = 0;
      @(negedge clk);
      bus.x_value = 10'd600;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (400) @(negedge clk);
      check("mid_run_enable", 32'(bus.lfsr_enable), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_enable", 32'(bus.lfsr_enable), 32'd0);
      check("abort_z_count", 32'(bus.z_count), 32'd0);
      check("abort_x_bit", 32'(bus.x_bit), 32'd0);
      check("abort_valid", 32'(bus.result_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_frame(10'd77, 1'b0, cnt, lat, n_rst, rst_lat, n_en);
      check_frame("after_abort", 11'd77, cnt, lat, n_rst, rst_lat, n_en);
      bus.result_ready = 1'b1;
      @(negedge clk);

      // Back-to-back with ready held high.
      run_frame(10'd5, 1'b0, cnt, lat, n_rst, rst_lat, n_en);
      check_frame("b2b_first", 11'd5, cnt, lat, n_rst, rst_lat, n_en);
      run_frame(10'd1000, 1'b0, cnt, lat, n_rst, rst_lat, n_en);
      check_frame("b2b_second", 11'd1000, cnt, lat, n_rst, rst_lat, n_en);
      @(negedge clk);
      check("b2b_done_valid", 32'(bus.result_valid), 32'd0);
      bus.result_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
